// File: rtl/ram_output_writer.sv
// Captures a streamed result matrix, one chunk per word, into local RAM.
// Optional readback port is built in when RAM_OUT_READBACK_EN is defined.
module ram_output_writer #(
  parameter int WIDTH           = 16,
  parameter int CHUNK_SIZE      = 4,
  parameter int OUTER_DIMENSION = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [WIDTH*CHUNK_SIZE-1:0] in_data,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            wr_addr,
  output logic                        busy,
  output logic                        done,
`ifdef RAM_OUT_READBACK_EN
  output logic                        drop_err,
  input  logic [WIDTH-1:0]            rd_addr,
  output logic [WIDTH*CHUNK_SIZE-1:0] rd_data
`else
  output logic                        drop_err
`endif
);

  localparam int DEPTH = (OUTER_DIMENSION*OUTER_DIMENSION)/CHUNK_SIZE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = WIDTH*CHUNK_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [DW-1:0]  mem [DEPTH];
  logic           accept;
  logic           last;

  assign busy     = (state == WRITE);
  assign done     = (state == DONE);
  assign in_ready = (state == WRITE);
  assign accept   = in_valid && (state == WRITE);
  assign last     = (wr_addr == WIDTH'(DEPTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_addr  <= '0;
      drop_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          // start outranks a same-cycle orphan chunk
          if (start) begin
            state    <= WRITE;
            wr_addr  <= '0;
            drop_err <= 1'b0;
          end else if (in_valid) begin
            drop_err <= 1'b1;
          end
        end
        WRITE: begin
          if (in_valid) begin
            if (last) begin
              state   <= DONE;
              wr_addr <= '0;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // storage carries no reset
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr[AW-1:0]] <= in_data;
  end

`ifdef RAM_OUT_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_addr < WIDTH'(DEPTH)) begin
      rd_data <= mem[rd_addr[AW-1:0]];
    end else begin
      rd_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ram_output_writer.sv
// Directed plus random checks of ram_output_writer against a
// transaction-level model of the capture protocol.
module tb_ram_output_writer;

  localparam int W     = 16;
  localparam int C     = 4;
  localparam int D     = 9;
  localparam int DW    = W*C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [W-1:0]  wr_addr;
  logic          busy;
  logic          done;
  logic          drop_err;
`ifdef RAM_OUT_READBACK_EN
  logic [W-1:0]  rd_addr = '0;
  logic [DW-1:0] rd_data;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: capture session as a simple counter of chunks
  bit            m_cap;
  int            m_cnt;
  bit            m_drop;
  bit            m_done;
  logic [DW-1:0] m_mem [D];
  bit            m_wr  [D];

  always #5 clk = ~clk;

  ram_output_writer #(.WIDTH(W), .CHUNK_SIZE(C), .OUTER_DIMENSION(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .done     (done),
`ifdef RAM_OUT_READBACK_EN
    .drop_err (drop_err),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`else
    .drop_err (drop_err)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".wr_addr"}, DW'(wr_addr), DW'(m_cnt));
    chk({tag, ".busy"},    DW'(busy),    DW'(m_cap));
    chk({tag, ".ready"},   DW'(in_ready), DW'(m_cap));
    chk({tag, ".done"},    DW'(done),    DW'(m_done));
    chk({tag, ".drop"},    DW'(drop_err), DW'(m_drop));
  endtask

  task automatic model_reset();
    m_cap = 0; m_cnt = 0; m_drop = 0; m_done = 0;
    for (int i = 0; i < D; i++) m_wr[i] = 0;
  endtask

  task automatic step(input string tag, input logic s, input logic v,
                      input logic [DW-1:0] d, input int ra);
    logic [DW-1:0] exp_rd;
    bit            rd_known;
    start = s; in_valid = v; in_data = d;
`ifdef RAM_OUT_READBACK_EN
    rd_addr = W'(ra);
`endif
    @(posedge clk);
    rd_known = (ra >= D) || m_wr[ra];
    exp_rd = (ra >= D) ? '0 : m_mem[ra];
    if (!m_cap) begin
      if (s) begin
        m_cap = 1; m_cnt = 0; m_drop = 0; m_done = 0;
      end else if (v) begin
        m_drop = 1;
      end
    end else if (v) begin
      m_mem[m_cnt] = d;
      m_wr[m_cnt] = 1;
      m_cnt++;
      if (m_cnt == D) begin
        m_cap = 0; m_done = 1; m_cnt = 0;
      end
    end
    #1;
    chk_all(tag);
`ifdef RAM_OUT_READBACK_EN
    if (rd_known) chk({tag, ".rd_data"}, rd_data, exp_rd);
`else
    if (rd_known && exp_rd === 'x) $display("unreachable");
`endif
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
`ifdef RAM_OUT_READBACK_EN
    chk({tag, ".rd_data"}, rd_data, '0);
`endif
    start = 0; in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] pat;
    model_reset();
    #2;
    pulse_reset("reset");

    // back-to-back capture of the counting pattern
    step("start0", 1, 0, '0, 0);
    for (int k = 0; k < D; k++) begin
      pat = {4{W'(k)}};
      step($sformatf("b2b%0d", k), 0, 1, pat, 0);
    end

    // readback of every word plus one out of range
    for (int a = 0; a <= D; a++)
      step($sformatf("rd%0d", a), 0, 0, '0, a);
    step("rd_tail", 0, 0, '0, 0);

    // orphan chunk in DONE sets the sticky error
    step("orphan", 0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0);
    step("orphan_hold", 0, 0, '0, 0);
    step("restart", 1, 0, '0, 0);

    // stalled stream: valid every other cycle
    for (int k = 0; k < 2*D; k++)
      step($sformatf("stall%0d", k), 0, k[0] == 1'b0, rnd64(), k % (D+1));

    // start during WRITE is ignored
    step("start1", 1, 0, '0, 0);
    for (int k = 0; k < 3; k++) step("pre", 0, 1, rnd64(), 0);
    step("ign_start", 1, 0, rnd64(), 0);
    for (int k = 0; k < 6; k++) step("post", 0, 1, rnd64(), k);

    // start and valid together in DONE: start wins, no drop
    step("st_vld", 1, 1, rnd64(), 0);

    // reset mid-capture, then fresh capture
    for (int k = 0; k < 4; k++) step("mid", 0, 1, rnd64(), 0);
    pulse_reset("reset_mid");
    step("idle_orphan", 0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0);
    step("start2", 1, 0, '0, 0);
    for (int k = 0; k < D; k++) step("fresh", 0, 1, rnd64(), k);
    for (int a = 0; a < D; a++) step("rd_fresh", 0, 0, '0, a);

    // random traffic
    for (int n = 0; n < 300; n++)
      step("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
           rnd64(), $urandom_range(0, D+1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
